// File: rtl/bulk_arb_pkg.sv
// Shared types for the bulk refill arbiter: FSM state encoding and the latched burst descriptor.
package bulk_arb_pkg;

    // Burst descriptor storage widths; instance ADDR_W/LEN_W must not exceed these.
    localparam int unsigned MaxAddrW = 64;
    localparam int unsigned MaxLenW  = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StRData = 3'd2,
        StWData = 3'd3,
        StWResp = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [MaxAddrW-1:0] addr;
        logic [MaxLenW-1:0]  len;
        logic                write;
    } burst_req_t;

endpackage

// File: rtl/bulk_refill_arbiter_if.sv
// Requester-side and memory-side bulk bus bundle shared by the arbiter and its environment.
interface bulk_refill_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LEN_W   = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_wvalid;
    logic [NUM_REQ-1:0]        req_wready;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_last;
    logic [NUM_REQ-1:0]        rsp_ready;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [ADDR_W-1:0]         mem_addr;
    logic [LEN_W-1:0]          mem_len;
    logic                      mem_write;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_wvalid;
    logic                      mem_wready;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      mem_rvalid;
    logic                      mem_rready;
    logic                      mem_bvalid;

    // Arbiter view.
    modport master (
        input  req_valid, req_addr, req_len, req_write, req_wdata, req_wvalid, rsp_ready,
        input  mem_ready, mem_wready, mem_rdata, mem_rvalid, mem_bvalid,
        output req_ready, req_wready, rsp_rdata, rsp_valid, rsp_last,
        output mem_valid, mem_addr, mem_len, mem_write, mem_wdata, mem_wvalid, mem_rready
    );

    // Environment view: requesters plus memory adapter.
    modport slave (
        output req_valid, req_addr, req_len, req_write, req_wdata, req_wvalid, rsp_ready,
        output mem_ready, mem_wready, mem_rdata, mem_rvalid, mem_bvalid,
        input  req_ready, req_wready, rsp_rdata, rsp_valid, rsp_last,
        input  mem_valid, mem_addr, mem_len, mem_write, mem_wdata, mem_wvalid, mem_rready
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping around.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IdxW    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o
);

    localparam int unsigned CandW = IdxW + 1;

    logic [CandW-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_i} + CandW'(off);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found                  = 1'b1;
                idx_o                  = cand[IdxW-1:0];
                gnt_o[cand[IdxW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bulk_refill_arbiter.sv
// Round-robin arbiter sharing one bulk memory port among NUM_REQ refill/writeback requesters.
// Optional per-requester grant/wait counters when BULK_ARB_PERF_CNT_EN is defined.
module bulk_refill_arbiter
    import bulk_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bulk_refill_arbiter_if.master  bus_io
`ifdef BULK_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*64-1:0]  perf_cnt_o
`endif
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    burst_req_t        burst_q, burst_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW-1:0]    ptr_wrap;
    logic [NUM_REQ-1:0] req_ready_int;
    logic               any_req;
    logic               last_beat;
    logic               rd_fire;
    logic               wr_fire;
    logic [DATA_W-1:0]  owner_wdata;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_pick (
        .req_i (bus_io.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign any_req     = |bus_io.req_valid;
    assign last_beat   = (beat_cnt_q == burst_q.len[LEN_W-1:0]);
    assign rd_fire     = (state_q == StRData) && bus_io.mem_rvalid && bus_io.rsp_ready[owner_q];
    assign wr_fire     = (state_q == StWData) && bus_io.req_wvalid[owner_q] && bus_io.mem_wready;
    assign ptr_wrap    = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
    assign owner_wdata = bus_io.req_wdata[owner_q*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d       = pick_idx;
                    burst_d.addr  = MaxAddrW'(bus_io.req_addr[pick_idx*ADDR_W +: ADDR_W]);
                    burst_d.len   = MaxLenW'(bus_io.req_len[pick_idx*LEN_W +: LEN_W]);
                    burst_d.write = bus_io.req_write[pick_idx];
                    state_d       = StAddr;
                end
            end
            StAddr: begin
                if (bus_io.mem_ready) begin
                    beat_cnt_d = '0;
                    state_d    = burst_q.write ? StWData : StRData;
                end
            end
            StRData: begin
                if (rd_fire) begin
                    if (last_beat) begin
                        state_d  = StIdle;
                        rr_ptr_d = ptr_wrap;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            StWData: begin
                if (wr_fire) begin
                    if (last_beat) begin
                        state_d = StWResp;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            StWResp: begin
                if (bus_io.mem_bvalid) begin
                    state_d  = StIdle;
                    rr_ptr_d = ptr_wrap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Everything outside the owner's current phase is held at zero.
    always_comb begin
        req_ready_int     = '0;
        bus_io.req_wready = '0;
        bus_io.rsp_valid  = '0;
        bus_io.rsp_rdata  = '0;
        bus_io.rsp_last   = 1'b0;
        bus_io.mem_valid  = 1'b0;
        bus_io.mem_wdata  = '0;
        bus_io.mem_wvalid = 1'b0;
        bus_io.mem_rready = 1'b0;
        unique case (state_q)
            StIdle: req_ready_int = pick_gnt;
            StAddr: bus_io.mem_valid = 1'b1;
            StRData: begin
                bus_io.mem_rready         = bus_io.rsp_ready[owner_q];
                bus_io.rsp_rdata          = bus_io.mem_rdata;
                bus_io.rsp_valid[owner_q] = bus_io.mem_rvalid;
                bus_io.rsp_last           = last_beat;
            end
            StWData: begin
                bus_io.mem_wdata           = owner_wdata;
                bus_io.mem_wvalid          = bus_io.req_wvalid[owner_q];
                bus_io.req_wready[owner_q] = bus_io.mem_wready;
            end
            StWResp: begin
                bus_io.rsp_valid[owner_q] = bus_io.mem_bvalid;
                bus_io.rsp_last           = bus_io.mem_bvalid;
            end
            default: ;
        endcase
    end

    assign bus_io.req_ready = req_ready_int;
    assign bus_io.mem_addr  = burst_q.addr[ADDR_W-1:0];
    assign bus_io.mem_len   = burst_q.len[LEN_W-1:0];
    assign bus_io.mem_write = burst_q.write;

`ifdef BULK_ARB_PERF_CNT_EN
    logic [31:0] grants_q [NUM_REQ];
    logic [31:0] wait_q   [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                grants_q[i] <= '0;
                wait_q[i]   <= '0;
            end else begin
                if (req_ready_int[i] && (grants_q[i] != '1)) begin
                    grants_q[i] <= grants_q[i] + 32'd1;
                end
                if (bus_io.req_valid[i] && !req_ready_int[i] && (wait_q[i] != '1)) begin
                    wait_q[i] <= wait_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_cnt_o[g*64 +: 64] = {wait_q[g], grants_q[g]};
    end
`endif

endmodule
